quad_gen: RTL and testbench
===========================

Name: quad_gen

Overview:
- Quadrature encoder emulator: converts single-cycle cw/ccw step requests into paced A/B quadrature waveforms.
- It is the transmit-side counterpart of the rotary-encoder decoder path in the lab2 design.
- Its a/b outputs drive enc1_a/enc1_b-style inputs, either in a loopback bench or on a header feeding another board.
- One step request produces one full quadrature cycle (4 edges). The paired decoder therefore reports exactly one cw or ccw pulse per request.

Parameters:
- DWELL, 50000: clock cycles between successive a/b edges (1 ms at 50 MHz). Legal range is 2 or more.
- PEND_W, 8: width of the signed step backlog. It saturates at ±(2^(PEND_W-1)-1).

Ports:
- clk, input, 1: system clock (CLOCK_50 at top level).
- reset_n, input, 1: asynchronous, active-low reset.
- cw, input, 1: single-cycle request for one clockwise step.
- ccw, input, 1: single-cycle request for one counter-clockwise step.
- a, output, 1: quadrature channel A (registered).
- b, output, 1: quadrature channel B (registered).
- busy, output, 1: high while a step is executing or the backlog is non-zero.
- ovf, output, 1: single-cycle pulse when a request is dropped because the backlog is saturated.

Behaviour:
- Reset (asynchronous, while reset_n=0):
  - a=0, b=0, phase=0, backlog=0, state=IDLE, timer=0, edge_cnt=0, busy=0, ovf=0.
  - Reset mid-step forces ab=00 immediately. A spurious decoder edge is acceptable.
- Phase encoding: phase 0..3 maps to ab = 00, 10, 11, 01.
  - CW steps phase +1 mod 4 (A leads B). CCW steps phase -1 mod 4.
  - Exactly one of a/b changes per edge.
- Backlog: signed count; positive means pending CW, negative means pending CCW.
  - cw only: +1. ccw only: -1. Both in the same cycle: no change, no ovf.
  - The update uses base = backlog minus the step-start consumption in the same cycle.
  - If base is already at +max and cw is requested (or -max and ccw), the request is dropped and ovf=1 for that cycle.
  - A request opposite to the backlog sign cancels one queued step.
- FSM states:
  - IDLE:
    - If backlog≠0, on that clock edge: latch dir=sign(backlog), move backlog one toward 0, set edge_cnt=4.
    - On the same edge, emit the first edge (phase±1, a/b updated), load timer=DWELL-1, go to RUN.
  - RUN:
    - While timer≠0: timer decrements; nothing else changes.
    - When timer==0 and edge_cnt>1: emit the next edge, decrement edge_cnt, reload timer.
    - When timer==0 and edge_cnt==1:
      - If backlog≠0, start the next step exactly as from IDLE, with no gap.
      - Otherwise go to IDLE.
- Latency:
  - A request sampled at edge k updates the backlog at k. The first a/b change follows edge k+1.
  - Within a burst, every edge is spaced exactly DWELL cycles. A step ends with phase back at its start value.
  - busy = (state≠IDLE) or (backlog≠0), registered-consistent with state.
- A step in progress always completes in its latched direction. Reversal takes effect only at a step boundary.
- Arithmetic:
  - timer width is $clog2(DWELL).
  - The backlog has no wrap-around; it saturates only.

Decomposition:
- Package quad_pkg:
  - phase_t (logic [1:0]).
  - state_t enum {IDLE, RUN}.
  - Function phase2ab(phase_t) returning the ab Gray mapping.
  - Constant EDGES_PER_STEP = 4.
- One sub-module, step_backlog:
  - Saturating signed up/down counter with a consume input.
  - Outputs: nonzero, sign, ovf.
- The FSM, timer and phase logic stay in quad_gen.

Test Plan:
- DWELL=4, one cw pulse at edge k → ab sequence 00→10→11→01→00 at edges k+1, k+5, k+9, k+13. busy falls after edge k+17. ovf stays 0.
- DWELL=4, one ccw pulse → ab sequence 00→01→11→10→00 with the same timing. Final phase is 0.
- DWELL=4, cw pulses at k, k+2, k+4 → 12 uniformly spaced edges (every 4 cycles) with no gap between steps. busy stays high throughout.
- cw=ccw=1 for one cycle while idle → no a/b activity, busy=0, ovf=0. Then cw, followed by ccw 2 cycles later → exactly one CW step; the queued request is cancelled.
- PEND_W=4, DWELL=4, cw held high for 10 cycles from k → ovf pulses at k+8 and k+9. 8 steps (32 edges) are produced.
- Loopback: quad_gen a/b into encoder + enc2bcd, DWELL=8, 5 cw then 2 ccw → bcd_count goes 00→05→03. Separately, reset_n pulsed low mid-step → ab=00, busy=0 immediately, with clean restart on the next request.

Source files
------------

// File: rtl/quad_pkg.sv
// Shared types and helpers for the quadrature encoder emulator.
// The phase-to-pin Gray mapping lives here so that every user agrees on the sequence.
package quad_pkg;

    typedef logic [1:0] phase_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int EDGES_PER_STEP = 4;

    // Phase 0..3 -> {a,b} = 00, 10, 11, 01, so neighbouring phases differ in one pin only.
    function automatic logic [1:0] phase2ab(input phase_t ph);
        logic [1:0] ab;
        case (ph)
            2'd0:    ab = 2'b00;
            2'd1:    ab = 2'b10;
            2'd2:    ab = 2'b11;
            2'd3:    ab = 2'b01;
            default: ab = 2'b00;
        endcase
        return ab;
    endfunction

endpackage

// File: rtl/quad_gen_step_backlog.sv
// Saturating signed step backlog: +1 per cw, -1 per ccw, one step toward zero per consume.
// Requests that would pass the saturation limit are dropped and flagged with a one-cycle ovf.
module step_backlog #(
    parameter int PEND_W = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_inc,
    input  logic i_dec,
    input  logic i_consume,
    output logic o_nonzero,
    output logic o_sign,
    output logic o_nz_nxt,
    output logic o_ovf
);

    localparam logic [PEND_W-1:0] ONE     = PEND_W'(1);
    localparam logic [PEND_W-1:0] POS_MAX = {1'b0, {(PEND_W-1){1'b1}}};
    localparam logic [PEND_W-1:0] NEG_MAX = ~POS_MAX + ONE;

    logic [PEND_W-1:0] r_count;
    logic              r_ovf;
    logic [PEND_W-1:0] w_base;
    logic [PEND_W-1:0] w_next;
    logic              w_ovf;

    // Consumption is applied first so a request arriving on a step-start edge sees the freed slot.
    always_comb begin
        w_base = r_count;
        if (i_consume && (r_count != PEND_W'(0))) begin
            if (r_count[PEND_W-1]) begin
                w_base = r_count + ONE;
            end else begin
                w_base = r_count - ONE;
            end
        end else begin
            w_base = r_count;
        end

        w_next = w_base;
        w_ovf  = 1'b0;
        if (i_inc && !i_dec) begin
            if (w_base == POS_MAX) begin
                w_ovf = 1'b1;
            end else begin
                w_next = w_base + ONE;
            end
        end else if (i_dec && !i_inc) begin
            if (w_base == NEG_MAX) begin
                w_ovf = 1'b1;
            end else begin
                w_next = w_base - ONE;
            end
        end else begin
            w_next = w_base;
        end
    end

    // Backlog and drop-flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= PEND_W'(0);
            r_ovf   <= 1'b0;
        end else begin
            r_count <= w_next;
            r_ovf   <= w_ovf;
        end
    end

    assign o_nonzero = (r_count != PEND_W'(0));
    assign o_sign    = r_count[PEND_W-1];
    assign o_nz_nxt  = (w_next != PEND_W'(0));
    assign o_ovf     = r_ovf;

endmodule

// File: rtl/quad_gen.sv
// Quadrature encoder emulator: each queued cw/ccw step becomes one full A/B cycle
// of four edges, each edge spaced DWELL clocks, with back-to-back steps gap-free.
module quad_gen
    import quad_pkg::*;
#(
    parameter int DWELL  = 50000,
    parameter int PEND_W = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic cw,
    input  logic ccw,
    output logic a,
    output logic b,
    output logic busy,
    output logic ovf
);

    localparam int            TW     = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [TW-1:0] T_LOAD = TW'(DWELL - 1);
    localparam logic [TW-1:0] T_ZERO = TW'(0);
    localparam logic [TW-1:0] T_ONE  = TW'(1);

    state_t      r_state;
    phase_t      r_phase;
    logic [1:0]  r_ab;
    logic [TW-1:0] r_timer;
    logic [2:0]  r_edge_cnt;
    logic        r_dir;
    logic        r_busy;

    logic        w_nonzero;
    logic        w_sign;
    logic        w_nz_nxt;
    logic        w_ovf;
    logic        w_step_done;
    logic        w_start;
    logic        w_step_dir;
    phase_t      w_phase_step;

    step_backlog #(
        .PEND_W(PEND_W)
    ) u_backlog (
        .clk       (clk),
        .rst_n     (reset_n),
        .i_inc     (cw),
        .i_dec     (ccw),
        .i_consume (w_start),
        .o_nonzero (w_nonzero),
        .o_sign    (w_sign),
        .o_nz_nxt  (w_nz_nxt),
        .o_ovf     (w_ovf)
    );

    // A new step starts from IDLE, or on the last dwell of a step when more work is queued.
    always_comb begin
        w_step_done  = (r_state == RUN) && (r_timer == T_ZERO) && (r_edge_cnt == 3'd1);
        w_start      = w_nonzero && ((r_state == IDLE) || w_step_done);
        w_step_dir   = w_start ? w_sign : r_dir;
        w_phase_step = w_step_dir ? (r_phase - 2'd1) : (r_phase + 2'd1);
    end

    // Step sequencer: direction latch, edge pacing, phase and registered a/b/busy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_phase    <= 2'd0;
            r_ab       <= 2'b00;
            r_timer    <= T_ZERO;
            r_edge_cnt <= 3'd0;
            r_dir      <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            if (w_start) begin
                r_state    <= RUN;
                r_dir      <= w_sign;
                r_phase    <= w_phase_step;
                r_ab       <= phase2ab(w_phase_step);
                r_timer    <= T_LOAD;
                r_edge_cnt <= 3'(EDGES_PER_STEP);
                r_busy     <= 1'b1;
            end else if (r_state == RUN) begin
                if (r_timer != T_ZERO) begin
                    r_timer <= r_timer - T_ONE;
                    r_busy  <= 1'b1;
                end else if (r_edge_cnt != 3'd1) begin
                    r_phase    <= w_phase_step;
                    r_ab       <= phase2ab(w_phase_step);
                    r_edge_cnt <= r_edge_cnt - 3'd1;
                    r_timer    <= T_LOAD;
                    r_busy     <= 1'b1;
                end else begin
                    r_state <= IDLE;
                    r_busy  <= w_nz_nxt;
                end
            end else begin
                r_state <= IDLE;
                r_busy  <= w_nz_nxt;
            end
        end
    end

    assign a    = r_ab[1];
    assign b    = r_ab[0];
    assign busy = r_busy;
    assign ovf  = w_ovf;

endmodule

// File: tb/tb_quad_gen.sv
// Randomized and directed bench for quad_gen against an event-time reference model
// (backlog integer, edges-left counter and absolute next-edge cycle).
module tb_quad_gen;

    localparam int DWELL = 4;
    localparam int PEND_W = 4;
    localparam int MAXB = 7;
    localparam int EDGES = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic cw = 1'b0;
    logic ccw = 1'b0;
    logic a, b, busy, ovf;

    quad_gen #(.DWELL(DWELL), .PEND_W(PEND_W)) dut (
        .clk(clk), .reset_n(reset_n), .cw(cw), .ccw(ccw),
        .a(a), .b(b), .busy(busy), .ovf(ovf)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    int m_cyc = 0;
    int m_backlog, m_phase, m_dir, m_left, m_next;
    bit m_active, m_ovf;

    task automatic check_vec(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: {a,b,busy,ovf} got %b expected %b (cycle %0d)", tag, got, exp, m_cyc);
        end
    endtask

    function automatic logic [1:0] ab_of(input int ph);
        logic pa, pb;
        pa = (ph == 1) || (ph == 2);
        pb = (ph == 2) || (ph == 3);
        return {pa, pb};
    endfunction

    function automatic logic [3:0] model_out();
        logic mb;
        mb = m_active || (m_backlog != 0);
        return {ab_of(m_phase), mb, m_ovf};
    endfunction

    task automatic model_reset();
        m_backlog = 0; m_phase = 0; m_dir = 1; m_left = 0; m_next = 0;
        m_active = 1'b0; m_ovf = 1'b0;
    endtask

    task automatic model_step(input bit c, input bit cc);
        bit start;
        m_cyc++;
        start = 1'b0;
        m_ovf = 1'b0;
        if (!m_active) begin
            start = (m_backlog != 0);
        end else if (m_cyc == m_next) begin
            if (m_left > 0) begin
                m_phase = (m_phase + m_dir + 4) % 4;
                m_left--;
                m_next = m_cyc + DWELL;
            end else if (m_backlog != 0) begin
                start = 1'b1;
            end else begin
                m_active = 1'b0;
            end
        end
        if (start) begin
            m_dir = (m_backlog > 0) ? 1 : -1;
            m_backlog -= m_dir;
            m_phase = (m_phase + m_dir + 4) % 4;
            m_left = EDGES - 1;
            m_next = m_cyc + DWELL;
            m_active = 1'b1;
        end
        if (c && !cc) begin
            if (m_backlog == MAXB) m_ovf = 1'b1;
            else m_backlog++;
        end else if (cc && !c) begin
            if (m_backlog == -MAXB) m_ovf = 1'b1;
            else m_backlog--;
        end
    endtask

    task automatic tick(input bit c, input bit cc);
        cw = c;
        ccw = cc;
        @(posedge clk);
        model_step(c, cc);
        #1;
        check_vec("cycle", {a, b, busy, ovf}, model_out());
    endtask

    task automatic drain();
        logic mb;
        for (int i = 0; i < 600 && (m_active || m_backlog != 0); i++) tick(1'b0, 1'b0);
        mb = m_active || (m_backlog != 0);
        check_vec("drain_bound", {3'b000, mb}, 4'b0000);
        tick(1'b0, 1'b0);
    endtask

    task automatic async_reset();
        #2;
        reset_n = 1'b0;
        #1;
        check_vec("async_reset", {a, b, busy, ovf}, 4'b0000);
        model_reset();
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        int p;
        model_reset();
        #12;
        check_vec("reset_state", {a, b, busy, ovf}, 4'b0000);
        reset_n = 1'b1;

        tick(1'b1, 1'b0);
        repeat (24) tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        repeat (24) tick(1'b0, 1'b0);
        tick(1'b1, 1'b1);
        repeat (5) tick(1'b0, 1'b0);
        tick(1'b1, 1'b0); tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b1);
        drain();
        tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b1, 1'b0);
        drain();
        repeat (10) tick(1'b1, 1'b0);
        drain();
        repeat (10) tick(1'b0, 1'b1);
        drain();
        tick(1'b1, 1'b0);
        repeat (6) tick(1'b0, 1'b0);
        async_reset();
        tick(1'b1, 1'b0);
        drain();

        p = 5;
        for (int i = 0; i < 4000; i++) begin
            if ((i % 200) == 0) p = ($urandom_range(0, 1) == 0) ? 4 : 40;
            tick($urandom_range(0, 99) < p, $urandom_range(0, 99) < p);
            if ($urandom_range(0, 499) == 0) async_reset();
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
